// File: rtl/sccb_responder.sv
// sccb_responder: SCCB write target backed by a 256x8 register bank.
// Oversamples sioc/siod in the clk domain; only ever pulls siod low.
module sccb_responder #(
   parameter logic [7:0] DEV_ID = 8'h42,
   parameter bit         ACK_EN = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       sioc,
   inout  wire        siod,
   output logic       wr_valid,
   output logic [7:0] wr_addr,
   output logic [7:0] wr_data,
   output logic       busy,
   output logic       err,
   input  logic [7:0] rd_addr,
   output logic [7:0] rd_data
);

   typedef enum logic [2:0] {
      IDLE,
      RX_ID,
      RX_ADDR,
      RX_DATA,
      SKIP
   } state_t;

   logic [2:0] scl_q;
   logic [2:0] sda_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         scl_q <= 3'b111;
         sda_q <= 3'b111;
      end else begin
         scl_q <= {scl_q[1:0], sioc};
         sda_q <= {sda_q[1:0], siod};
      end
   end

   logic scl;
   logic scl_d;
   logic sda;
   logic sda_d;
   logic scl_rise;
   logic scl_fall;
   logic start;
   logic stop;

   assign scl      = scl_q[1];
   assign scl_d    = scl_q[2];
   assign sda      = sda_q[1];
   assign sda_d    = sda_q[2];
   assign scl_rise = scl & ~scl_d;
   assign scl_fall = ~scl & scl_d;
   assign start    = scl & scl_d & ~sda & sda_d;
   assign stop     = scl & scl_d & sda & ~sda_d;

   state_t     state;
   logic [3:0] cnt;
   logic [6:0] sh;
   logic       hi;
   logic       ack_pend;
   logic       ack_drv;
   logic       extra;
   logic       extra_hi;
   logic [7:0] ptr;
   logic [7:0] rx_byte;
   logic       commit;

   assign rx_byte = {sh, sda};
   assign commit  = (state == RX_DATA) && scl_rise
                    && (cnt == 4'd7);

   // A bit only counts once its falling edge is seen, so the
   // rising sioc that precedes a STOP never looks like a partial byte.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= 4'd0;
         sh       <= 7'd0;
         hi       <= 1'b0;
         ack_pend <= 1'b0;
         ack_drv  <= 1'b0;
         extra    <= 1'b0;
         extra_hi <= 1'b0;
         ptr      <= 8'd0;
         wr_valid <= 1'b0;
         wr_addr  <= 8'd0;
         wr_data  <= 8'd0;
         busy     <= 1'b0;
         err      <= 1'b0;
      end else begin
         wr_valid <= 1'b0;
         err      <= 1'b0;
         if (start || stop) begin
            if (state != IDLE && cnt != 4'd0)
               err <= 1'b1;
            cnt      <= 4'd0;
            hi       <= 1'b0;
            ack_pend <= 1'b0;
            ack_drv  <= 1'b0;
            extra    <= 1'b0;
            extra_hi <= 1'b0;
            if (start) begin
               state <= RX_ID;
               busy  <= 1'b1;
            end else begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         end else if (state != IDLE) begin
            if (scl_rise) begin
               hi <= 1'b1;
               if (state == SKIP) begin
                  if (extra)
                     extra_hi <= 1'b1;
               end else if (cnt < 4'd8) begin
                  sh <= {sh[5:0], sda};
                  if (cnt == 4'd7) begin
                     unique case (state)
                        RX_ID: begin
                           if (rx_byte == DEV_ID) begin
                              ack_pend <= ACK_EN;
                           end else begin
                              state <= SKIP;
                              cnt   <= 4'd0;
                           end
                        end
                        RX_ADDR: begin
                           ptr      <= rx_byte;
                           ack_pend <= ACK_EN;
                        end
                        RX_DATA: begin
                           wr_valid <= 1'b1;
                           wr_addr  <= ptr;
                           wr_data  <= rx_byte;
                           ack_pend <= ACK_EN;
                        end
                        default: ;
                     endcase
                  end
               end
            end else if (scl_fall) begin
               hi <= 1'b0;
               if (ack_drv) begin
                  ack_drv <= 1'b0;
               end else if (ack_pend) begin
                  ack_drv  <= 1'b1;
                  ack_pend <= 1'b0;
               end
               if (hi) begin
                  if (state == SKIP) begin
                     if (extra_hi) begin
                        err      <= 1'b1;
                        extra    <= 1'b0;
                        extra_hi <= 1'b0;
                     end
                  end else if (cnt == 4'd8) begin
                     cnt <= 4'd0;
                     unique case (state)
                        RX_ID:   state <= RX_ADDR;
                        RX_ADDR: state <= RX_DATA;
                        RX_DATA: begin
                           state <= SKIP;
                           extra <= 1'b1;
                        end
                        default: ;
                     endcase
                  end else begin
                     cnt <= cnt + 4'd1;
                  end
               end
            end
         end
      end
   end

   assign siod = ack_drv ? 1'b0 : 1'bz;

   logic [7:0] mem [256];

   always_ff @(posedge clk) begin
      if (!reset && commit)
         mem[ptr] <= rx_byte;
   end

   always_ff @(posedge clk) begin
      if (reset)
         rd_data <= 8'd0;
      else
         rd_data <= mem[rd_addr];
   end

endmodule

// File: tb/tb_sccb_responder.sv
// tb_sccb_responder: bit-banged SCCB sender plus a transaction-level
// model of the responder's acks, commits, errors and bank contents.
module tb_sccb_responder;

   logic       clk     = 1'b0;
   logic       reset   = 1'b1;
   logic       sioc    = 1'b1;
   logic       sda_oe  = 1'b0;
   logic [7:0] rd_addr = 8'h00;
   wire        siod;
   logic       wr_valid;
   logic [7:0] wr_addr;
   logic [7:0] wr_data;
   logic       busy;
   logic       err;
   logic [7:0] rd_data;

   assign siod = sda_oe ? 1'b0 : 1'bz;
   pullup (siod);

   sccb_responder #(
      .DEV_ID(8'h42),
      .ACK_EN(1'b1)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .sioc    (sioc),
      .siod    (siod),
      .wr_valid(wr_valid),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .busy    (busy),
      .err     (err),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] a;
      logic [7:0] d;
   } wr_t;

   wr_t        expq[$];
   logic [7:0] mbank [256];
   bit         mknown [256];
   logic [7:0] m_addr   = 8'h00;
   logic [7:0] m_data   = 8'h00;
   int         n_chk    = 0;
   int         n_fail   = 0;
   int         err_seen = 0;
   int         err_exp  = 0;
   int         P        = 32;
   logic [7:0] txq[$];

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Bank and last-commit model, checked one step after every clk edge.
   initial begin
      wr_t w;
      forever begin
         @(posedge clk);
         #1;
         if (reset) begin
            check("rst_wr_valid", wr_valid, 0);
            check("rst_err", err, 0);
            check("rst_busy", busy, 0);
            check("rst_wr_addr", wr_addr, 0);
            check("rst_wr_data", wr_data, 0);
            check("rst_rd_data", rd_data, 0);
            m_addr = 8'h00;
            m_data = 8'h00;
         end else begin
            if (mknown[rd_addr])
               check("rd_data", rd_data, mbank[rd_addr]);
            if (wr_valid) begin
               if (expq.size() == 0) begin
                  n_chk++;
                  n_fail++;
                  $display("FAIL unexpected_write: got %0h=%0h want none",
                           wr_addr, wr_data);
               end else begin
                  w = expq.pop_front();
                  check("commit_addr", wr_addr, w.a);
                  check("commit_data", wr_data, w.d);
                  m_addr = w.a;
                  m_data = w.d;
                  mbank[w.a] = w.d;
                  mknown[w.a] = 1'b1;
               end
            end
            check("wr_addr_hold", wr_addr, m_addr);
            check("wr_data_hold", wr_data, m_data);
            if (err)
               err_seen++;
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bit(input bit b, input bit do_rst, output bit s);
      tick(P / 4);
      sda_oe = ~b;
      tick(P - P / 4);
      sioc = 1'b1;
      tick(P / 2);
      s = siod;
      if (do_rst) begin
         reset = 1'b1;
         tick(1);
         reset = 1'b0;
         check("rst_mid_siod", siod, 1);
         check("rst_mid_busy", busy, 0);
         check("rst_mid_wr_valid", wr_valid, 0);
         check("rst_mid_err", err, 0);
         check("rst_mid_wr_addr", wr_addr, 0);
         check("rst_mid_wr_data", wr_data, 0);
         check("rst_mid_rd_data", rd_data, 0);
         tick(P - P / 2 - 1);
      end else begin
         tick(P - P / 2);
      end
      sioc = 1'b0;
   endtask

   task automatic bus_start();
      sda_oe = 1'b0;
      sioc   = 1'b1;
      tick(P);
      sda_oe = 1'b1;
      tick(P);
      sioc = 1'b0;
   endtask

   task automatic bus_stop();
      tick(P / 4);
      sda_oe = 1'b1;
      tick(P - P / 4);
      sioc = 1'b1;
      tick(P);
      sda_oe = 1'b0;
      tick(P);
   endtask

   // Sends txq, then npart bits of a partial byte, then STOP.
   // rst_byte >= 0 pulses reset inside that byte's ACK slot.
   task automatic send_txn(input int npart, input int rst_byte);
      bit         s;
      bit         dead;
      bit         killed;
      bit         exp_ack;
      logic [7:0] addr;
      logic [7:0] b;
      wr_t        w;
      int         nb;
      nb     = txq.size();
      dead   = 1'b0;
      killed = 1'b0;
      addr   = 8'h00;
      bus_start();
      check("busy_start", busy, 1);
      for (int i = 0; i < nb; i++) begin
         b       = txq[i];
         exp_ack = 1'b0;
         if (!dead) begin
            if (i == 0) begin
               exp_ack = (b == 8'h42);
               dead    = !exp_ack;
            end else if (i == 1) begin
               exp_ack = 1'b1;
               addr    = b;
            end else if (i == 2) begin
               exp_ack = 1'b1;
               w.a     = addr;
               w.d     = b;
               expq.push_back(w);
            end else if (i == 3) begin
               err_exp++;
            end
         end
         for (int k = 7; k >= 0; k--) begin
            send_bit(b[k], 1'b0, s);
            check("data_line", s, b[k]);
         end
         send_bit(1'b1, i == rst_byte, s);
         check("ack", s, exp_ack ? 0 : 1);
         if (i == rst_byte) begin
            dead   = 1'b1;
            killed = 1'b1;
         end
      end
      if (npart > 0) begin
         b = 8'hA5;
         for (int k = 0; k < npart; k++)
            send_bit(b[7 - k], 1'b0, s);
         if (!dead && nb < 3)
            err_exp++;
      end
      check("busy_pre_stop", busy, killed ? 0 : 1);
      bus_stop();
      check("busy_stop", busy, 0);
      check("pending_writes", expq.size(), 0);
      check("err_count", err_seen, err_exp);
   endtask

   initial begin
      tick(3);
      reset = 1'b0;
      tick(2);

      P   = 256;
      txq = '{8'h42, 8'h12, 8'h80};
      send_txn(0, -1);
      rd_addr = 8'h12;
      tick(3);
      check("lit_rd_12", rd_data, 8'h80);
      check("lit_addr_12", wr_addr, 8'h12);
      check("lit_data_80", wr_data, 8'h80);

      P   = 32;
      txq = '{8'h60, 8'h12, 8'h55};
      send_txn(0, -1);
      txq = '{8'h43};
      send_txn(0, -1);
      txq = '{8'h42, 8'h3A};
      send_txn(0, -1);
      check("lit_two_phase_err", err_seen, 0);
      txq = '{8'h42, 8'h3A, 8'h04};
      send_txn(0, -1);
      check("lit_addr_3a", wr_addr, 8'h3A);
      check("lit_data_04", wr_data, 8'h04);

      txq = '{8'h42, 8'h11, 8'h5C};
      send_txn(0, -1);
      txq = '{8'h42, 8'h11};
      send_txn(4, -1);
      check("lit_abort_err", err_seen, 1);
      rd_addr = 8'h11;
      tick(3);
      check("lit_rd_11", rd_data, 8'h5C);

      txq = '{8'h42, 8'h05, 8'h66, 8'h77};
      send_txn(0, -1);
      check("lit_extra_err", err_seen, 2);

      txq = '{8'h42, 8'h20, 8'h77};
      send_txn(0, 2);
      txq = '{8'h42, 8'h01, 8'hAA};
      send_txn(0, -1);
      check("lit_addr_01", wr_addr, 8'h01);
      check("lit_data_aa", wr_data, 8'hAA);
      rd_addr = 8'h01;
      tick(3);
      check("lit_rd_01", rd_data, 8'hAA);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
